// File: rtl/inference_check_pkg.sv
// Shared constants for the on-board inference check scheduler.
// Holds the FSM encoding, the output vector width and the phase-end helper.
package inference_check_pkg;

    localparam int OUT_W         = 32'd80;
    localparam int CNT_W_DEFAULT = 32'd16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_START = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_CHECK = 3'd3;
    localparam state_t S_HOLD  = 3'd4;
    localparam state_t S_GAP   = 3'd5;

    // A zero-length phase still occupies one cycle, so len == 0 counts as last.
    function automatic logic is_last(input logic [31:0] timer, input logic [31:0] len);
        return (len == 32'd0) || (timer == (len - 32'd1));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32'd16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    // Count qualifying events, saturating at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + ONE;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/inference_check_scheduler.sv
// Repeats network inference runs, checks each result against the golden vector,
// shows the outcome on active-low LEDs and keeps saturating run statistics.
module inference_check_scheduler
    import inference_check_pkg::*;
#(
    parameter logic [OUT_W-1:0] MODEL_OUTPUT = 80'h1D471500200000B00037,
    parameter int unsigned      FREQUENCY    = 32'd50000000,
    parameter int unsigned      RUN_GAP      = 32'd25000000,
    parameter int unsigned      TIMEOUT      = 32'd1000000,
    parameter int               CNT_W        = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             net_start,
    input  logic             net_done,
    input  logic [OUT_W-1:0] din,
    output logic             pass_led,
    output logic             fail_led,
    output logic             busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    state_t             state_r;
    state_t             next_state_s;
    logic [31:0]        timer_r;
    logic [OUT_W-1:0]   result_r;
    logic               pass_led_s;
    logic               fail_led_s;
    logic               pass_inc_s;
    logic               fail_inc_s;
    logic               timeout_inc_s;
    logic               match_s;

    // Next-state, LED and counter-increment decisions.
    always_comb begin
        next_state_s  = state_r;
        pass_led_s    = pass_led;
        fail_led_s    = fail_led;
        pass_inc_s    = 1'b0;
        fail_inc_s    = 1'b0;
        timeout_inc_s = 1'b0;
        match_s       = (result_r == MODEL_OUTPUT);
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    next_state_s = S_START;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_START: begin
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                // A done strobe on the timeout cycle takes priority.
                if (net_done) begin
                    next_state_s = S_CHECK;
                end else if (is_last(timer_r, TIMEOUT)) begin
                    next_state_s  = S_HOLD;
                    timeout_inc_s = 1'b1;
                    pass_led_s    = 1'b1;
                    fail_led_s    = 1'b0;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_CHECK: begin
                next_state_s = S_HOLD;
                if (match_s) begin
                    pass_inc_s = 1'b1;
                    pass_led_s = 1'b0;
                    fail_led_s = 1'b1;
                end else begin
                    fail_inc_s = 1'b1;
                    pass_led_s = 1'b1;
                    fail_led_s = 1'b0;
                end
            end
            S_HOLD: begin
                if (is_last(timer_r, FREQUENCY)) begin
                    next_state_s = S_GAP;
                    pass_led_s   = 1'b1;
                    fail_led_s   = 1'b1;
                end else begin
                    next_state_s = S_HOLD;
                end
            end
            S_GAP: begin
                if (is_last(timer_r, RUN_GAP)) begin
                    next_state_s = enable ? S_START : S_IDLE;
                end else begin
                    next_state_s = S_GAP;
                end
            end
            default: begin
                next_state_s = S_IDLE;
                pass_led_s   = 1'b1;
                fail_led_s   = 1'b1;
            end
        endcase
    end

    // State, shared phase timer, captured result and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            timer_r   <= 32'd0;
            result_r  <= '0;
            net_start <= 1'b0;
            busy      <= 1'b0;
            pass_led  <= 1'b1;
            fail_led  <= 1'b1;
        end else begin
            state_r <= next_state_s;
            if ((next_state_s != state_r) || (state_r == S_IDLE)) begin
                timer_r <= 32'd0;
            end else begin
                timer_r <= timer_r + 32'd1;
            end
            if ((state_r == S_WAIT) && net_done) begin
                result_r <= din;
            end else begin
                result_r <= result_r;
            end
            net_start <= (next_state_s == S_START);
            busy      <= (next_state_s == S_WAIT);
            pass_led  <= pass_led_s;
            fail_led  <= fail_led_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pass_inc_s),
        .q     (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fail_inc_s),
        .q     (fail_cnt)
    );

    sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (timeout_inc_s),
        .q     (timeout_cnt)
    );

endmodule

// File: doc/inference_check_scheduler.md
Name: inference_check_scheduler

Overview:
- Sequences repeated on-board inference runs for FPGA verification of the MNIST network.
- Each run: issues a start pulse to the network top, waits for its done strobe (with timeout), captures the 80-bit output vector and compares it against a golden value.
- Drives active-low pass/fail LEDs for a hold time and maintains saturating pass/fail/timeout counters for debug readout.
- Sits between the network top and the board peripherals (LEDs, debug registers).

Parameters:
- MODEL_OUTPUT, 80'h1D471500200000B00037, golden output vector for the test image.
- FREQUENCY, 50000000, clk cycles per second; LED hold time = FREQUENCY cycles.
- RUN_GAP, 25000000, idle cycles between end of LED hold and next start pulse.
- TIMEOUT, 1000000, max cycles from start pulse to done before declaring timeout.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, level; 1 = run continuously, 0 = stop after the current run completes.
- net_start, output, 1, single-cycle start pulse to the network.
- net_done, input, 1, single-cycle strobe from the network; din is valid in the same cycle.
- din, input, 80, network output vector.
- pass_led, output, 1, active-low; 0 = last run matched.
- fail_led, output, 1, active-low; 0 = last run mismatched or timed out.
- busy, output, 1, high from start pulse until done or timeout.
- pass_cnt, output, CNT_W, count of matching runs.
- fail_cnt, output, CNT_W, count of mismatching runs.
- timeout_cnt, output, CNT_W, count of timed-out runs.

Behaviour:
Reset values (asynchronous, while rst_n = 0):
- net_start = 0, busy = 0, pass_led = 1, fail_led = 1.
- All counters = 0, state = IDLE, timer = 0.

State machine:
- IDLE: if enable = 1, go to START; otherwise stay.
- START: net_start = 1 for exactly this one cycle; timer cleared; next state WAIT.
- WAIT: busy = 1; timer increments each cycle.
  - net_done = 1: register din into result_q, go to CHECK.
  - Otherwise, if timer == TIMEOUT-1: timeout_cnt += 1, fail_led = 0, pass_led = 1, go to HOLD.
  - If net_done and timeout coincide, done wins and no timeout is counted.
- CHECK (one cycle): compare result_q with MODEL_OUTPUT.
  - Equal: pass_cnt += 1, pass_led = 0, fail_led = 1.
  - Not equal: fail_cnt += 1, fail_led = 0, pass_led = 1.
  - Timer cleared; go to HOLD.
- HOLD: count FREQUENCY cycles. On the final cycle, both LEDs return to 1 and the next state is GAP.
- GAP: count RUN_GAP cycles, then go to START if enable = 1, else IDLE. RUN_GAP = 0 means GAP lasts exactly one cycle.

Timing and handshake:
- Latency from net_done to the LED update is 2 cycles: capture, then compare and register.
- busy is high only in WAIT.
- net_done outside WAIT is ignored, with no counter change.
- Deasserting enable never aborts a run in progress; the FSM finishes through HOLD and GAP, then parks in IDLE.

Counters:
- Saturate at all-ones and never wrap.
- Exactly one counter increments per completed run.

Timer:
- A single 32-bit counter shared by WAIT, HOLD and GAP, cleared on every state entry.
- Comparisons are unsigned.

Reset mid-operation:
- Immediately returns to reset values.
- Any in-flight done from the network is lost and not counted.

Decomposition:
- Package inference_check_pkg:
  - State encoding (IDLE, START, WAIT, CHECK, HOLD, GAP) as localparams, 3-bit.
  - OUT_W = 80.
  - Counter width default.
- One sub-module, sat_counter:
  - Ports: clk, rst_n, inc, q.
  - Parameter W.
  - Instantiated three times for the statistics counters.

Test Plan:
(Bench parameters: FREQUENCY = 20, RUN_GAP = 5, TIMEOUT = 30, CNT_W = 4.)
- Single pass: enable = 1; net_done 10 cycles after net_start with din = MODEL_OUTPUT → pass_led = 0 two cycles later, held for 20 cycles, then 1; pass_cnt = 1, others 0.
- Mismatch: din = MODEL_OUTPUT ^ 80'h1 → fail_led = 0 for 20 cycles; fail_cnt = 1; pass_led stays 1.
- Timeout: never assert net_done → at cycle 30 after start, fail_led = 0 and timeout_cnt = 1; a late net_done during HOLD changes no counter.
- Done and timeout in the same cycle (done on timer = 29) with a matching din → counted as pass, timeout_cnt unchanged.
- Continuous runs:
  - Keep enable high for 18 matching runs → pass_cnt saturates at 4'hF.
  - The gap between a net_start pulse and the next is exactly 1 + 10 + 1 + 20 + 5 cycles.
  - Each net_start pulse is exactly 1 cycle wide.
- Control during a run:
  - enable dropped in WAIT → run completes, then FSM parks in IDLE with no further net_start.
  - rst_n asserted in HOLD → LEDs = 1 and counters = 0 immediately (asynchronously).
